// File: rtl/single_port_ram_pkg.sv
// rtl/single_port_ram_pkg.sv - default geometry for the single-port RAM
package single_port_ram_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;

endpackage

// File: rtl/single_port_ram.sv
// rtl/single_port_ram.sv - 256x8 flop-based RAM, registered read, write-first on rd+wr
module single_port_ram
  import single_port_ram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out
);

  localparam int RAM_DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [RAM_DEPTH];
  logic [DATA_W-1:0] d_out_q;
  logic [DATA_W-1:0] d_out_d;

  // Write-first: a simultaneous read returns the incoming data, not the old word.
  always_comb begin
    d_out_d = d_out_q;
    if (rd) begin
      d_out_d = wr ? d_in : mem_q[addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_out_q <= '0;
      for (int i = 0; i < RAM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      d_out_q <= d_out_d;
      if (wr) begin
        mem_q[addr] <= d_in;
      end
    end
  end

  assign d_out = d_out_q;

endmodule

// File: tb/tb_single_port_ram.sv
// tb/tb_single_port_ram.sv - directed self-checking bench for single_port_ram
module tb_single_port_ram;

  logic       clk;
  logic       rst_n;
  logic       rd;
  logic       wr;
  logic [7:0] addr;
  logic [7:0] d_in;
  logic [7:0] d_out;

  int n_checks;
  int n_errors;
  logic [7:0] model [256];

  single_port_ram #(.DATA_W(8), .ADDR_W(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rd    (rd),
    .wr    (wr),
    .addr  (addr),
    .d_in  (d_in),
    .d_out (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%02h expected=0x%02h", tag, got, exp);
    end
  endtask

  // Drive one cycle of strobes, sample 1ns after the edge, then go idle.
  task automatic op(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    rd = r; wr = w; addr = a; d_in = d;
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_model();
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = 8'h00; d_in = 8'h00;
    #1;
    check("reset_dout", d_out, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    op(1, 0, 8'h00, 8'h00); check("rst_rd_00", d_out, 8'h00);
    op(1, 0, 8'h7F, 8'h00); check("rst_rd_7f", d_out, 8'h00);
    op(1, 0, 8'hFF, 8'h00); check("rst_rd_ff", d_out, 8'h00);

    op(0, 1, 8'h00, 8'h24); check("wr_only_hold", d_out, 8'h00);
    op(1, 0, 8'h00, 8'h00); check("wr_rd_24", d_out, 8'h24);
    op(0, 0, 8'h00, 8'h00); check("idle_hold", d_out, 8'h24);

    for (int a = 0; a < 256; a++) begin
      logic [7:0] v;
      v = 8'($urandom_range(0, 255));
      op(0, 1, 8'(a), v);
      model[a] = v;
    end
    for (int a = 0; a < 256; a++) begin
      op(1, 0, 8'(a), 8'h00);
      check($sformatf("fill_rd_%02h", a), d_out, model[a]);
    end

    op(0, 1, 8'h10, 8'h81);
    op(1, 0, 8'h10, 8'h00); check("pre_rw_81", d_out, 8'h81);
    op(1, 1, 8'h10, 8'h09); check("rw_write_first", d_out, 8'h09);
    op(1, 0, 8'h10, 8'h00); check("rw_after_rd", d_out, 8'h09);

    op(0, 1, 8'h20, 8'h63);
    op(1, 0, 8'h20, 8'h00); check("hold_rd_63", d_out, 8'h63);
    op(0, 1, 8'h21, 8'h0D); check("hold_after_wr", d_out, 8'h63);
    op(1, 0, 8'h21, 8'h00); check("hold_wr_stored", d_out, 8'h0D);

    // Mid-run asynchronous reset, asserted between edges.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst_dout", d_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    op(1, 0, 8'h00, 8'h00); check("mid_rst_rd_00", d_out, 8'h00);
    op(1, 0, 8'h7F, 8'h00); check("mid_rst_rd_7f", d_out, 8'h00);
    op(1, 0, 8'hFF, 8'h00); check("mid_rst_rd_ff", d_out, 8'h00);
    op(1, 0, 8'h10, 8'h00); check("mid_rst_rd_10", d_out, 8'h00);

    op(0, 1, 8'hFF, 8'hAA);
    op(0, 1, 8'h00, 8'h55);
    op(1, 0, 8'hFF, 8'h00); check("iso_rd_ff", d_out, 8'hAA);
    op(1, 0, 8'h00, 8'h00); check("iso_rd_00", d_out, 8'h55);
    op(1, 0, 8'h01, 8'h00); check("iso_rd_01", d_out, 8'h00);

    // Write pending across an edge that falls inside reset is discarded.
    @(negedge clk);
    wr = 1'b1; addr = 8'h40; d_in = 8'h77;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    wr = 1'b0;
    check("pend_rst_dout", d_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    op(1, 0, 8'h40, 8'h00); check("pend_wr_lost", d_out, 8'h00);
    op(1, 0, 8'hFF, 8'h00); check("pend_rst_ff", d_out, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
